scan_decoder: RTL and testbench
===============================

# scan_decoder

Registered, parametrised N-to-2^N one-hot decoder with enable, extending the 2-to-4 enable decoder with three operating modes. Direct decode drives a clocked one-hot select. One-shot pulse issues a timed strobe. Auto-scan walks the asserted line through all outputs with a programmable dwell. It drives register-bank and mux select lines where a clean, glitch-free, cycle-accurate select is needed.

## Interface
- ADDR_WIDTH, 2, address width N; output count is 2^N (N ≥ 1).
- PULSE_LEN, 1, cycles a one-shot pulse stays asserted (≥ 1).
- SCAN_DWELL, 1, cycles each output stays asserted in scan mode (≥ 1).

- clk  input  1  single clock; all state updates on the rising edge.
- nReset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- enable  input  1  global enable; gates every mode.
- address  input  ADDR_WIDTH  decode index; also the scan start index.
- mode  input  2  operating mode: 00 direct, 01 pulse, 10 scan, 11 freeze.
- load  input  1  command strobe for pulse and scan modes.
- out  output  2^ADDR_WIDTH  registered one-hot select; bit i set means output i is active.
- curAddr  output  ADDR_WIDTH  index of the most recently asserted output.
- busy  output  1  high while a pulse or scan is in progress.

## Operation
- States: IDLE, PULSE, SCAN. Reset puts the block in IDLE with out=0, curAddr=0, busy=0, and the pulse and dwell counters at 0.
- IDLE, mode 00 (direct): each cycle, out <= enable ? (1<<address) : 0. When enable=1, curAddr <= address. Loads are ignored.
- IDLE, mode 01: out <= 0. If load=1 and enable=1, set out <= 1<<address and curAddr <= address, load the pulse counter, and move to PULSE.
- PULSE: out holds its value for exactly PULSE_LEN cycles, then out <= 0 and the state returns to IDLE.
  - mode, enable and load are ignored while in PULSE; a pulse always completes.
- IDLE, mode 10: out <= 0. If load=1 and enable=1, set out <= 1<<address and curAddr <= address, clear the dwell counter, and move to SCAN.
- SCAN: after each SCAN_DWELL cycles on one index, the index advances by 1 modulo 2^N (2^N-1 wraps to 0). out and curAddr follow the index, and the dwell counter restarts.
  - If enable=0 or mode≠10 is sampled at any edge in SCAN, the next state is IDLE and out <= 0 on that edge. That edge produces no advance.
  - load is ignored in SCAN.
- IDLE, mode 11 (freeze): out, curAddr and all counters hold. Loads are ignored.
- busy = (state ≠ IDLE). It is registered and aligned with out.
- out is only ever 0 or one-hot; two bits are never set at once.
- curAddr holds its value whenever out=0.

## Timing
- Latency is 1 cycle from sampled inputs to out in every mode. No combinational path from inputs to outputs.
- Load accepted at edge k:
  - PULSE: out and busy are high from edge k through edge k+PULSE_LEN-1, and low at edge k+PULSE_LEN. A load sampled at edge k+PULSE_LEN is accepted.
  - SCAN: index i occupies edges k..k+SCAN_DWELL-1, and i+1 starts at edge k+SCAN_DWELL.
- With SCAN_DWELL=1 the output advances every cycle. With PULSE_LEN=1 the pulse is a single-cycle strobe.
- nReset=0 at any edge, in any state (mid-pulse or mid-scan included), forces the full reset values at that edge. Reset overrides load.
- A mode change in IDLE takes effect at the same edge. Switching from 00 to 01 or 10 clears out on that edge unless a load is accepted there.

## Test plan
- Direct mode, enable=1, address sweeps 0,1,2,3 → out = 0001, 0010, 0100, 1000, each one cycle after the input. enable=0 → out=0000 for all four addresses.
- Pulse mode with PULSE_LEN=3, address=2, single-cycle load at edge k → out=0100 and busy=1 at edges k..k+2, both 0 at edge k+3. A second load at edge k+1 is ignored.
- Scan mode with SCAN_DWELL=2, start address 3 → out goes 1000 ×2, 0001 ×2, 0010 ×2 (wrap verified), with curAddr tracking 3, 0, 1.
- Scan abort: drop enable mid-dwell → out=0000 and busy=0 on that edge. Repeat with mode changed to 00 instead → same result, then direct decode resumes on the following edge.
- Assert nReset=0 mid-pulse and mid-scan, with load=1 held → out=0, busy=0, curAddr=0 on that edge. Confirm freeze mode holds out and curAddr constant for 10 cycles regardless of address and load.

Source files
------------

// File: rtl/scan_decoder.sv
// scan_decoder: registered N-to-2^N one-hot decoder with enable and three
// operating modes.
//   mode 00 direct : out follows 1<<address every cycle while enable=1.
//   mode 01 pulse  : a load issues a one-hot strobe lasting PULSE_LEN cycles.
//   mode 10 scan   : a load starts walking the active line upward from
//                    address, SCAN_DWELL cycles per index, wrapping at 2^N.
//   mode 11 freeze : out, curAddr and counters hold.
// Ports:
//   clk      - rising-edge clock
//   nReset   - synchronous active-low reset
//   enable   - global enable, gates every mode
//   address  - decode index / scan start index
//   mode     - operating mode select
//   load     - command strobe for pulse and scan modes
//   out      - registered one-hot select (or all zero)
//   curAddr  - index of the most recently asserted output
//   busy     - high while a pulse or scan is in progress
module scan_decoder #(
  parameter int ADDR_WIDTH = 2,
  parameter int PULSE_LEN  = 1,
  parameter int SCAN_DWELL = 1
) (
  input  logic                         clk,
  input  logic                         nReset,
  input  logic                         enable,
  input  logic [ADDR_WIDTH-1:0]        address,
  input  logic [1:0]                   mode,
  input  logic                         load,
  output logic [(1<<ADDR_WIDTH)-1:0]   out,
  output logic [ADDR_WIDTH-1:0]        curAddr,
  output logic                         busy
);

  localparam int NOUT = 1 << ADDR_WIDTH;
  localparam int PCW  = (PULSE_LEN  > 1) ? $clog2(PULSE_LEN)  : 1;
  localparam int DCW  = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
  localparam logic [PCW-1:0] PLAST = PCW'(PULSE_LEN - 1);
  localparam logic [DCW-1:0] DLAST = DCW'(SCAN_DWELL - 1);

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_PULSE  = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    SCAN
  } state_t;

  state_t                  state, state_n;
  logic [NOUT-1:0]         out_n;
  logic [ADDR_WIDTH-1:0]   cur_n;
  logic [ADDR_WIDTH-1:0]   nxt_idx;
  logic [PCW-1:0]          pcnt, pcnt_n;
  logic [DCW-1:0]          dcnt, dcnt_n;
  logic [NOUT-1:0]         addr_hot;
  logic [NOUT-1:0]         next_hot;
  logic                    accept_pulse;
  logic                    accept_scan;
  logic                    can_launch;

  assign addr_hot     = NOUT'(1) << address;
  assign nxt_idx      = curAddr + ADDR_WIDTH'(1);
  assign next_hot     = NOUT'(1) << nxt_idx;
  assign accept_pulse = enable && load && (mode == MODE_PULSE);
  assign accept_scan  = enable && load && (mode == MODE_SCAN);
  // The final edge of a pulse behaves like IDLE for load acceptance, so a
  // back-to-back command issued on that edge is not lost.
  assign can_launch   = (state == IDLE) || ((state == PULSE) && (pcnt == '0));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state   <= IDLE;
      out     <= '0;
      curAddr <= '0;
      pcnt    <= '0;
      dcnt    <= '0;
    end else begin
      state   <= state_n;
      out     <= out_n;
      curAddr <= cur_n;
      pcnt    <= pcnt_n;
      dcnt    <= dcnt_n;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_n = state;
    out_n   = out;
    cur_n   = curAddr;
    pcnt_n  = pcnt;
    dcnt_n  = dcnt;

    case (state)
      IDLE: begin
        case (mode)
          MODE_DIRECT: begin
            out_n = enable ? addr_hot : '0;
            if (enable) begin
              cur_n = address;
            end
          end
          MODE_PULSE, MODE_SCAN: out_n = '0;
          default: ;  // freeze: everything holds
        endcase
      end
      PULSE: begin
        if (pcnt == '0) begin
          state_n = IDLE;
          out_n   = '0;
        end else begin
          pcnt_n = pcnt - PCW'(1);
        end
      end
      SCAN: begin
        if (!enable || (mode != MODE_SCAN)) begin
          state_n = IDLE;
          out_n   = '0;
        end else if (dcnt == DLAST) begin
          cur_n  = nxt_idx;
          out_n  = next_hot;
          dcnt_n = '0;
        end else begin
          dcnt_n = dcnt + DCW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        out_n   = '0;
      end
    endcase

    if (can_launch && accept_pulse) begin
      state_n = PULSE;
      out_n   = addr_hot;
      cur_n   = address;
      pcnt_n  = PLAST;
    end else if (can_launch && accept_scan) begin
      state_n = SCAN;
      out_n   = addr_hot;
      cur_n   = address;
      dcnt_n  = '0;
    end
  end

  // Outputs derived from registered state
  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder (ADDR_WIDTH=2, PULSE_LEN=3,
// SCAN_DWELL=2). Stimulus drives on the falling edge and queues the
// hand-computed response for the following rising edge; a monitor pops and
// compares one entry just after every rising edge.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       nReset;
  logic       enable;
  logic [1:0] address;
  logic [1:0] mode;
  logic       load;
  logic [3:0] out;
  logic [1:0] curAddr;
  logic       busy;

  typedef struct {
    logic [3:0] o;
    logic [1:0] c;
    logic       b;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;

  scan_decoder #(
    .ADDR_WIDTH (2),
    .PULSE_LEN  (3),
    .SCAN_DWELL (2)
  ) dut (
    .clk     (clk),
    .nReset  (nReset),
    .enable  (enable),
    .address (address),
    .mode    (mode),
    .load    (load),
    .out     (out),
    .curAddr (curAddr),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Monitor: every rising edge produces one response.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (out !== e.o || curAddr !== e.c || busy !== e.b) begin
        failures++;
        $display("FAIL %s: got out=%b curAddr=%0d busy=%b, expected out=%b curAddr=%0d busy=%b",
                 e.nm, out, curAddr, busy, e.o, e.c, e.b);
      end
    end
  end

  task automatic step(input logic nr, input logic en, input logic [1:0] m,
                      input logic [1:0] a, input logic ld,
                      input logic [3:0] eo, input logic [1:0] ec,
                      input logic eb, input string nm);
    exp_t e;
    @(negedge clk);
    nReset  = nr;
    enable  = en;
    mode    = m;
    address = a;
    load    = ld;
    e.o = eo; e.c = ec; e.b = eb; e.nm = nm;
    q.push_back(e);
  endtask

  initial begin
    nReset = 1'b0; enable = 1'b0; mode = 2'b00; address = '0; load = 1'b0;

    // Reset
    step(0, 0, 2'b00, 2'd0, 0, 4'b0000, 2'd0, 0, "reset0");
    step(0, 1, 2'b01, 2'd3, 1, 4'b0000, 2'd0, 0, "reset1");

    // Direct mode, enabled sweep then disabled sweep
    step(1, 1, 2'b00, 2'd0, 0, 4'b0001, 2'd0, 0, "direct_a0");
    step(1, 1, 2'b00, 2'd1, 1, 4'b0010, 2'd1, 0, "direct_a1");
    step(1, 1, 2'b00, 2'd2, 0, 4'b0100, 2'd2, 0, "direct_a2");
    step(1, 1, 2'b00, 2'd3, 0, 4'b1000, 2'd3, 0, "direct_a3");
    for (int i = 0; i < 4; i++)
      step(1, 0, 2'b00, 2'(i), 0, 4'b0000, 2'd3, 0, "direct_dis");

    // Pulse mode: idle, disabled load ignored, then a 3-cycle pulse
    step(1, 1, 2'b01, 2'd2, 0, 4'b0000, 2'd3, 0, "pulse_idle");
    step(1, 0, 2'b01, 2'd2, 1, 4'b0000, 2'd3, 0, "pulse_dis_load");
    step(1, 1, 2'b01, 2'd2, 1, 4'b0100, 2'd2, 1, "pulse_k");
    step(1, 1, 2'b01, 2'd1, 1, 4'b0100, 2'd2, 1, "pulse_k1_reload");
    step(1, 1, 2'b00, 2'd1, 0, 4'b0100, 2'd2, 1, "pulse_k2");
    step(1, 1, 2'b01, 2'd1, 0, 4'b0000, 2'd2, 0, "pulse_end");

    // Back-to-back: load on the terminating edge is accepted
    step(1, 1, 2'b01, 2'd1, 1, 4'b0010, 2'd1, 1, "pulse2_k");
    step(1, 1, 2'b01, 2'd1, 0, 4'b0010, 2'd1, 1, "pulse2_k1");
    step(1, 1, 2'b01, 2'd1, 0, 4'b0010, 2'd1, 1, "pulse2_k2");
    step(1, 1, 2'b01, 2'd0, 1, 4'b0001, 2'd0, 1, "pulse3_k");
    step(1, 1, 2'b01, 2'd0, 0, 4'b0001, 2'd0, 1, "pulse3_k1");
    step(1, 1, 2'b01, 2'd0, 0, 4'b0001, 2'd0, 1, "pulse3_k2");
    step(1, 1, 2'b01, 2'd0, 0, 4'b0000, 2'd0, 0, "pulse3_end");

    // Scan from 3 with wrap, then abort by enable=0
    step(1, 1, 2'b10, 2'd3, 1, 4'b1000, 2'd3, 1, "scan_3a");
    step(1, 1, 2'b10, 2'd0, 1, 4'b1000, 2'd3, 1, "scan_3b");
    step(1, 1, 2'b10, 2'd0, 0, 4'b0001, 2'd0, 1, "scan_0a");
    step(1, 1, 2'b10, 2'd0, 0, 4'b0001, 2'd0, 1, "scan_0b");
    step(1, 1, 2'b10, 2'd0, 0, 4'b0010, 2'd1, 1, "scan_1a");
    step(1, 1, 2'b10, 2'd0, 0, 4'b0010, 2'd1, 1, "scan_1b");
    step(1, 1, 2'b10, 2'd0, 0, 4'b0100, 2'd2, 1, "scan_2a");
    step(1, 0, 2'b10, 2'd0, 0, 4'b0000, 2'd2, 0, "scan_abort_en");

    // Scan aborted by mode change, then direct resumes
    step(1, 1, 2'b10, 2'd0, 1, 4'b0001, 2'd0, 1, "scan_b_start");
    step(1, 1, 2'b00, 2'd3, 0, 4'b0000, 2'd0, 0, "scan_abort_mode");
    step(1, 1, 2'b00, 2'd3, 0, 4'b1000, 2'd3, 0, "direct_resume");

    // Reset mid-pulse and mid-scan with load held
    step(1, 1, 2'b01, 2'd1, 1, 4'b0010, 2'd1, 1, "rst_pulse_start");
    step(0, 1, 2'b01, 2'd1, 1, 4'b0000, 2'd0, 0, "rst_mid_pulse");
    step(1, 1, 2'b01, 2'd1, 0, 4'b0000, 2'd0, 0, "rst_pulse_after");
    step(1, 1, 2'b10, 2'd2, 1, 4'b0100, 2'd2, 1, "rst_scan_start");
    step(0, 1, 2'b10, 2'd2, 1, 4'b0000, 2'd0, 0, "rst_mid_scan");

    // Freeze holds for 10 cycles regardless of address and load
    step(1, 1, 2'b00, 2'd2, 0, 4'b0100, 2'd2, 0, "pre_freeze");
    for (int i = 0; i < 10; i++)
      step(1, 1'(i % 3 != 0), 2'b11, 2'(i), 1'(i % 2), 4'b0100, 2'd2, 0, "freeze");
    step(1, 1, 2'b01, 2'd0, 0, 4'b0000, 2'd2, 0, "freeze_to_pulse");

    // Drain, bounded
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
